// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: grant encoding,
// default widths and the write-request payload.
package rf_arb_pkg;

  localparam int DEF_A_WIDTH = 5;
  localparam int DEF_D_WIDTH = 32;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_AUX
  } grant_e;

  typedef struct packed {
    logic [DEF_A_WIDTH-1:0] ad;
    logic [DEF_D_WIDTH-1:0] wd;
  } wr_req_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Synchronous FIFO of write requests buffering the aux return path.
// Push while full and pop while empty are ignored; DEPTH must be a power of two.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter type T     = wr_req_t,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file's single write port between writeback and a
// buffered aux return path. Define RF_WRITE_ARBITER_BYPASS_EN for same-cycle aux bypass.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int  A_WIDTH      = DEF_A_WIDTH,
  parameter int  D_WIDTH      = DEF_D_WIDTH,
  parameter int  FIFO_DEPTH   = 4,
  parameter int  STARVE_LIMIT = 3,
  localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_valid,
  output logic                        wb_ready,
  input  logic [A_WIDTH-1:0]          wb_ad,
  input  logic [D_WIDTH-1:0]          wb_wd,
  input  logic                        aux_valid,
  output logic                        aux_ready,
  input  logic [A_WIDTH-1:0]          aux_ad,
  input  logic [D_WIDTH-1:0]          aux_wd,
  output logic                        we3,
  output logic [A_WIDTH-1:0]          ad3,
  output logic [D_WIDTH-1:0]          wd3,
  output logic                        aux_pending,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  typedef struct packed {
    logic [A_WIDTH-1:0] ad;
    logic [D_WIDTH-1:0] wd;
  } req_t;

  req_t          aux_in;
  req_t          head;
  req_t          gnt_req;
  grant_e        grant;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          starved;
  logic [SW-1:0] starve_cnt;

  assign aux_in.ad = aux_ad;
  assign aux_in.wd = aux_wd;

  rf_arb_fifo #(
    .T     (req_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (aux_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    grant      = GNT_NONE;
    bypass     = 1'b0;
    gnt_req.ad = wb_ad;
    gnt_req.wd = wb_wd;
    starved    = !empty && (starve_cnt == SW'(STARVE_LIMIT));
    wb_ready   = !rst && !starved;
    aux_ready  = !rst && !full;

    if (rst) begin
      grant = GNT_NONE;
    end else if (!empty && (!wb_valid || starved)) begin
      grant   = GNT_AUX;
      gnt_req = head;
    end else if (wb_valid) begin
      grant = GNT_WB;
`ifdef RF_WRITE_ARBITER_BYPASS_EN
    end else if (aux_valid) begin
      // FIFO is empty here, so the aux request can go straight to the port.
      grant   = GNT_AUX;
      bypass  = 1'b1;
      gnt_req = aux_in;
`endif
    end

    push = aux_valid && aux_ready && !bypass;
    pop  = (grant == GNT_AUX) && !bypass;
  end

  assign aux_pending = !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      we3        <= 1'b0;
      ad3        <= '0;
      wd3        <= '0;
      starve_cnt <= '0;
    end else begin
      if (grant != GNT_NONE) begin
        // Writes to x0 are consumed but never reach the register file.
        we3 <= (gnt_req.ad != '0);
        ad3 <= gnt_req.ad;
        wd3 <= gnt_req.wd;
      end else begin
        we3 <= 1'b0;
      end

      if ((grant == GNT_AUX) || empty) begin
        starve_cnt <= '0;
      end else if ((grant == GNT_WB) && (starve_cnt != SW'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a queue-based reference model predicts
// handshakes and register-file writes; a monitor compares each cycle's write port.
module tb_rf_write_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef RF_WRITE_ARBITER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [AW-1:0] wb_ad = '0;
  logic [DW-1:0] wb_wd = '0;
  logic          aux_valid = 1'b0;
  logic          aux_ready;
  logic [AW-1:0] aux_ad = '0;
  logic [DW-1:0] aux_wd = '0;
  logic          we3;
  logic [AW-1:0] ad3;
  logic [DW-1:0] wd3;
  logic          aux_pending;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .A_WIDTH      (AW),
    .D_WIDTH      (DW),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_ad       (wb_ad),
    .wb_wd       (wb_wd),
    .aux_valid   (aux_valid),
    .aux_ready   (aux_ready),
    .aux_ad      (aux_ad),
    .aux_wd      (aux_wd),
    .we3         (we3),
    .ad3         (ad3),
    .wd3         (wd3),
    .aux_pending (aux_pending),
    .fifo_count  (fifo_count)
  );

  typedef struct {
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
  } req_s;

  typedef struct {
    logic          we;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    int            cyc;
  } exp_s;

  req_s aux_buf[$];
  exp_s sb[$];
  int   wb_streak = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   wb_taken = 1'b0;
  bit   aux_taken = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: evaluated on the falling edge with the inputs the next
  // rising edge will sample.
  always @(negedge clk) begin : model
    bit   pend;
    bit   exp_wbr;
    bit   exp_auxr;
    bit   byp_now;
    int   gsel;
    req_s g;
    if (rst) begin
      check("wb_ready_rst", wb_ready, 0);
      check("aux_ready_rst", aux_ready, 0);
      aux_buf.delete();
      wb_streak = 0;
      wb_taken  = 1'b0;
      aux_taken = 1'b0;
    end else begin
      pend     = (aux_buf.size() != 0);
      exp_wbr  = !(pend && wb_streak == LIMIT);
      exp_auxr = (aux_buf.size() < DEPTH);
      check("wb_ready", wb_ready, exp_wbr);
      check("aux_ready", aux_ready, exp_auxr);
      check("fifo_count", fifo_count, aux_buf.size());
      check("aux_pending", aux_pending, pend);

      gsel    = 0;
      byp_now = 1'b0;
      g.ad    = wb_ad;
      g.wd    = wb_wd;
      if (pend && (!wb_valid || wb_streak == LIMIT)) begin
        gsel = 2;
        g    = aux_buf.pop_front();
      end else if (wb_valid) begin
        gsel = 1;
      end else if (BYP && aux_valid) begin
        gsel    = 2;
        byp_now = 1'b1;
        g.ad    = aux_ad;
        g.wd    = aux_wd;
      end

      if (gsel == 2 || !pend) wb_streak = 0;
      else if (gsel == 1 && wb_streak < LIMIT) wb_streak++;

      wb_taken  = wb_valid && exp_wbr;
      aux_taken = aux_valid && exp_auxr;
      if (aux_taken && !byp_now) aux_buf.push_back('{ad: aux_ad, wd: aux_wd});
      if (gsel != 0) sb.push_back('{we: (g.ad != 0), ad: g.ad, wd: g.wd, cyc: cyc + 1});
    end
  end

  // Monitor: compares the registered write port against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_s e;
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("we3", we3, e.we);
      check("ad3", ad3, e.ad);
      check("wd3", wd3, e.wd);
    end else begin
      check("we3_idle", we3, 0);
    end
  end

  // Presents a request unless the previous one is still waiting for ready.
  task automatic step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wdat,
                      input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] adat);
    if (!(wb_valid && !wb_taken)) begin
      wb_valid = wv;
      wb_ad    = wa;
      wb_wd    = wdat;
    end
    if (!(aux_valid && !aux_taken)) begin
      aux_valid = av;
      aux_ad    = aa;
      aux_wd    = adat;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held with both requesters active.
    rst = 1'b1;
    step(1, 5'd3, 32'h1111, 1, 5'd4, 32'h2222);
    step(1, 5'd3, 32'h1111, 1, 5'd4, 32'h2222);
    rst = 1'b0;
    idle(4);

    // wb-only write, then a write to x0.
    step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    step(1, 5'd0, 32'h0BAD0BAD, 0, '0, '0);
    idle(2);

    // aux-only write.
    step(0, '0, '0, 1, 5'd10, 32'h1);
    idle(4);

    // Starvation: one aux entry under continuous wb traffic.
    step(1, 5'd1, 32'hB0, 1, 5'd12, 32'hA0);
    for (int i = 0; i < 7; i++) step(1, 5'(i + 2), 32'hB1 + i, 0, '0, '0);
    idle(4);

    // Fill the FIFO behind wb traffic; a fifth aux request has to wait.
    for (int i = 0; i < 10; i++)
      step(1, 5'(16 + i), 32'hC0 + i, (i < 5), 5'(24 + (i % 8)), 32'hD0 + i);
    idle(12);

    // Randomized phases of varying density, with occasional mid-run resets.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 500; i++) begin
        bit            wv;
        bit            av;
        logic [AW-1:0] wa;
        logic [AW-1:0] aa;
        wv = ($urandom_range(0, 99) < 30 + ph * 20);
        av = ($urandom_range(0, 99) < 20 + ph * 15);
        wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rst = ($urandom_range(0, 249) == 0);
        step(wv, wa, $urandom, av, aa, $urandom);
      end
      rst = 1'b0;
      idle(3);
    end

    idle(12);
    check("scoreboard_drained", sb.size(), 0);
    check("fifo_drained", fifo_count, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
